// File: rtl/led_fb_pkg.sv
// Shared sizing for the LED frame buffer and LedCtrl, plus the buffer's control state type.
package led_fb_pkg;

    localparam int LED_DATA_W = 16;
    localparam int LED_DEPTH  = 256;
    localparam int LED_ADDR_W = $clog2(LED_DEPTH);

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } fbState_t;

endpackage

// File: rtl/led_fb_dpram.sv
// Simple dual-port RAM: one write port, one registered read port with an output-only reset.
module led_fb_dpram #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic              rdRst,
    input  logic              wrEn,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [DATA_W-1:0] wrData,
    input  logic              rdEn,
    input  logic [ADDR_W-1:0] rdAddr,
    output logic [DATA_W-1:0] rdData
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wrEn) mem[wrAddr] <= wrData;
    end

    // Only the output register resets; array contents survive reset.
    always_ff @(posedge clk) begin
        if (rdRst)     rdData <= '0;
        else if (rdEn) rdData <= mem[rdAddr];
    end

endmodule

// File: rtl/led_frame_buffer.sv
// Double-buffered LED frame store: the source fills the back bank, LedCtrl reads the front bank,
// and banks swap on a display frame boundary after a commit.
module led_frame_buffer
    import led_fb_pkg::*;
#(
    parameter int DATA_W = LED_DATA_W,
    parameter int DEPTH  = LED_DEPTH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wrValid,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [DATA_W-1:0] wrData,
    output logic              wrReady,
    input  logic              frameCommit,
    input  logic              rdFrameStart,
    input  logic              rdEn,
    input  logic [ADDR_W-1:0] rdaddress,
    output logic [DATA_W-1:0] ledColBuf,
    output logic              swapPending,
    output logic [7:0]        frameCount,
    output logic              overrun,
    input  logic              clrOverrun
);

    fbState_t state, stateNext;
    logic     frontBank, frontBankNext;
    logic     swapNow, commitDrop, wrDrop, wrAccept;

    assign swapPending = (state == PENDING);
    assign wrReady     = !swapPending;
    assign wrAccept    = wrValid && wrReady && !reset;
    assign wrDrop      = wrValid && !wrReady;

    always_comb begin
        stateNext  = state;
        swapNow    = 1'b0;
        commitDrop = 1'b0;
        case (state)
            IDLE: begin
                // A commit landing on a frame boundary swaps straight away.
                if (frameCommit) begin
                    if (rdFrameStart) swapNow   = 1'b1;
                    else              stateNext = PENDING;
                end
            end
            PENDING: begin
                if (frameCommit) commitDrop = 1'b1;
                if (rdFrameStart) begin
                    swapNow   = 1'b1;
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    assign frontBankNext = frontBank ^ swapNow;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            frontBank  <= 1'b0;
            frameCount <= 8'd0;
            overrun    <= 1'b0;
        end else begin
            state     <= stateNext;
            frontBank <= frontBankNext;
            if (swapNow) frameCount <= frameCount + 8'd1;
            // Set wins over clear so a coincident error is never lost.
            if (wrDrop || commitDrop) overrun <= 1'b1;
            else if (clrOverrun)      overrun <= 1'b0;
        end
    end

    // Writes use the pre-swap back bank; reads use the post-swap front bank.
    led_fb_dpram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W + 1)
    ) uRam (
        .clk    (clk),
        .rdRst  (reset),
        .wrEn   (wrAccept),
        .wrAddr ({~frontBank, wrAddr}),
        .wrData (wrData),
        .rdEn   (rdEn && !reset),
        .rdAddr ({frontBankNext, rdaddress}),
        .rdData (ledColBuf)
    );

endmodule

// File: doc/led_frame_buffer.md
LED_FRAME_BUFFER -- requirements
Module: led_frame_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 16: width of one LED column word, equal to the LedCtrl ledColBuf width.
REQ-002 SHALL have parameter DEPTH, default 256: column words per frame; power of two only.
REQ-003 SHALL have parameter ADDR_W, default $clog2(DEPTH): address width.
REQ-004 SHALL have port clk, input, 1: the only clock, the spiClk domain.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-006 SHALL have port wrValid, input, 1: write request from the frame source.
REQ-007 SHALL have port wrAddr, input, ADDR_W: write address in the back bank.
REQ-008 SHALL have port wrData, input, DATA_W: write data.
REQ-009 SHALL have port wrReady, output, 1: back bank accepts writes.
REQ-010 SHALL have port frameCommit, input, 1: one-cycle pulse marking the back bank as complete.
REQ-011 SHALL have port rdFrameStart, input, 1: one-cycle pulse from LedCtrl at the start of each display frame.
REQ-012 SHALL have port rdEn, input, 1: read strobe from LedCtrl.
REQ-013 SHALL have port rdaddress, input, ADDR_W: read address in the front bank.
REQ-014 SHALL have port ledColBuf, output, DATA_W: registered read data to LedCtrl.
REQ-015 SHALL have port swapPending, output, 1: a committed frame is waiting for the next rdFrameStart.
REQ-016 SHALL have port frameCount, output, 8: count of completed bank swaps.
REQ-017 SHALL have port overrun, output, 1: sticky error flag.
REQ-018 SHALL have port clrOverrun, input, 1: clears overrun.

Function
REQ-019 SHALL hold two banks of DEPTH x DATA_W; frontBank is read, and ~frontBank is written.
REQ-020 SHALL drive wrReady = !swapPending, combinationally.
REQ-021 SHALL write wrData to back[wrAddr] on a clk edge where wrValid && wrReady.
REQ-022 SHALL drop a write where wrValid && !wrReady, leaving memory unchanged, and set overrun.
REQ-023 SHALL set swapPending on frameCommit when swapPending=0 and rdFrameStart=0.
REQ-024 SHALL ignore frameCommit when swapPending=1, leaving state unchanged, and set overrun.
REQ-025 SHALL, on rdFrameStart with swapPending=1, toggle frontBank, clear swapPending and increment frameCount at the same edge.
REQ-026 SHALL, on frameCommit and rdFrameStart in the same cycle with swapPending=0, swap immediately: toggle frontBank and increment frameCount, with swapPending remaining 0.
REQ-027 SHALL leave all state unchanged on rdFrameStart with swapPending=0 and no commit; the old frame is re-displayed.
REQ-028 SHALL, when rdEn is high, load ledColBuf at the next edge with the front-bank word at rdaddress, giving 1-cycle latency.
REQ-029 SHALL use the post-swap front bank for a read issued in the same cycle as a swapping rdFrameStart.
REQ-030 SHALL hold ledColBuf when rdEn is low.
REQ-031 SHALL land a write to the back bank in the same cycle as a swap in the old back bank, which becomes the new front bank.
REQ-032 SHALL wrap frameCount from 255 to 0.
REQ-033 SHALL keep overrun sticky until clrOverrun; a set event coinciding with clrOverrun leaves overrun=1.

Reset
REQ-034 SHALL, on reset high at a clk edge, set ledColBuf=0, frontBank=0, swapPending=0, frameCount=0 and overrun=0.
REQ-035 SHALL NOT clear memory contents on reset.
REQ-036 SHALL discard any pending swap when reset is asserted mid-frame.
REQ-037 SHALL ignore all inputs during a reset cycle.

Structure
REQ-038 SHALL place DATA_W, DEPTH and ADDR_W defaults in package led_fb_pkg, shared with LedCtrl.
REQ-039 SHALL use one sub-module, led_fb_dpram: a simple dual-port RAM of 2*DEPTH words, address {bank, addr}, with a registered read.
REQ-040 SHALL keep the control FSM (IDLE and PENDING, i.e. swapPending) in led_frame_buffer.

Verification
REQ-041 SHALL cover: write 0x1234 @ 5, commit, rdFrameStart, rdEn with rdaddress=5 -> ledColBuf=0x1234 one cycle later, frameCount=1.
REQ-042 SHALL cover: commit, then wrValid before rdFrameStart -> wrReady=0, write dropped, overrun=1; clrOverrun -> overrun=0.
REQ-043 SHALL cover: frameCommit and rdFrameStart in the same cycle -> immediate swap, swapPending=0, frameCount increments.
REQ-044 SHALL cover: rdFrameStart with no commit -> frontBank unchanged; re-reading address 5 returns the prior data.
REQ-045 SHALL cover: 256 commit/swap cycles -> frameCount wraps to 0.
REQ-046 SHALL cover: commit, then reset before rdFrameStart -> swapPending=0, frontBank=0, ledColBuf=0.
